load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences word-addressed memory accesses for RISC-V loads and stores,
// with read-modify-write for byte/halfword stores. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
//   state | meaning
//   IDLE  | ready for a request
//   RD    | memory read (load data or word for read-modify-write)
//   WR    | memory write
//   RESP  | one-cycle completion pulse
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [1:0]         r_boff;
  logic [15:0]        r_wdata;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_wr_data;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic [1:0]         w_size;
  logic               w_legal;
  logic               w_bad;
  logic [1:0]         w_boff;
  logic               w_accept;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_rd_ext;
  logic [31:0]        w_merged;
  logic               w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_W+2];
  assign w_size   = req_funct3[1:0];
  assign w_legal  = req_we ? (!req_funct3[2] && (w_size != 2'd3))
                           : ((w_size != 2'd3) && !(req_funct3[2] && (w_size == 2'd2)));
  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((w_size == 2'd1) && req_addr[0]) ||
                      ((w_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_bad      = !w_legal || w_misalign;
  assign w_boff     = req_addr[1:0];
`else
  // Misaligned halfword/word accesses silently drop the low address bits.
  assign w_bad  = !w_legal;
  assign w_boff = (w_size == 2'd0) ? req_addr[1:0] :
                  (w_size == 2'd1) ? {req_addr[1], 1'b0} : 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_bad)                              w_next = S_RESP;
          else if (req_we && (w_size == 2'd2))    w_next = S_WR;
          else                                    w_next = S_RD;
        end
      end
      S_RD: begin
        mem_rd_en = 1'b1;
        w_next    = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_wr_en = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_boff)
      2'd0: w_byte = mem_rd_data[7:0];
      2'd1: w_byte = mem_rd_data[15:8];
      2'd2: w_byte = mem_rd_data[23:16];
      default: w_byte = mem_rd_data[31:24];
    endcase
    w_half = r_boff[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    w_rd_ext = mem_rd_data;
    case (r_funct3)
      3'b000: w_rd_ext = {{24{w_byte[7]}}, w_byte};
      3'b001: w_rd_ext = {{16{w_half[15]}}, w_half};
      3'b100: w_rd_ext = {24'h000000, w_byte};
      3'b101: w_rd_ext = {16'h0000, w_half};
      default: w_rd_ext = mem_rd_data;
    endcase

    w_merged = mem_rd_data;
    if (r_funct3[1:0] == 2'd0) begin
      case (r_boff)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_boff[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // Response fields only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_boff     <= 2'b00;
      r_wdata    <= 16'h0000;
      r_mem_addr <= '0;
      r_wr_data  <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_boff   <= w_boff;
            r_wdata  <= req_wdata[15:0];
            if (w_bad) begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
            end else begin
              r_mem_addr <= req_addr[ADDR_W+1:2];
              if (req_we && (w_size == 2'd2)) r_wr_data <= req_wdata;
            end
          end
        end
        S_RD: begin
          if (r_we) begin
            r_wr_data <= w_merged;
          end else begin
            r_rdata <= w_rd_ext;
            r_err   <= 1'b0;
          end
        end
        S_WR: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_wr_data;

endmodule
